// File: rtl/logic_gate_pipe.sv
// Bitwise 2-input logic stage with valid/ready on both sides, a main result register plus one skid entry,
// and a saturating output-handshake counter. Define LOGIC_PIPE_PARITY_EN to add the out_par port (^out_y).
module logic_gate_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
`ifdef LOGIC_PIPE_PARITY_EN
    output logic             out_par,
`endif
    output logic [CNT_W-1:0] xfer_cnt
);

`ifdef LOGIC_PIPE_PARITY_EN
    localparam int EW = WIDTH + 1;
`else
    localparam int EW = WIDTH;
`endif

    logic [WIDTH-1:0] res;
    logic [EW-1:0]    ent_new;
    logic [EW-1:0]    main_q, main_d, skid_q, skid_d;
    logic             main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
    logic             rdy_q, rdy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept, drain;

    always_comb begin
        res = '0;
        case (in_op)
            3'b000:  res = in_a & in_b;
            3'b001:  res = in_a | in_b;
            3'b010:  res = ~(in_a & in_b);
            3'b011:  res = ~(in_a | in_b);
            3'b100:  res = in_a ^ in_b;
            3'b101:  res = ~(in_a ^ in_b);
            3'b110:  res = ~in_a;
            default: res = in_a;
        endcase
    end

    // Parity travels with the result so it stays aligned through the skid entry.
`ifdef LOGIC_PIPE_PARITY_EN
    assign ent_new = {^res, res};
`else
    assign ent_new = res;
`endif

    assign accept = in_valid & rdy_q;
    assign drain  = main_vld_q & out_ready;

    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        cnt_d      = cnt_q;
        if (drain) begin
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
            if (skid_vld_q) begin
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end else if (accept) begin
                main_d = ent_new;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_vld_q) begin
                main_d     = ent_new;
                main_vld_d = 1'b1;
            end else begin
                skid_d     = ent_new;
                skid_vld_d = 1'b1;
            end
        end
        // Registered ready: low for the whole cycle the skid entry is occupied.
        rdy_d = !skid_vld_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= '0;
            main_vld_q <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
            rdy_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            main_q     <= main_d;
            main_vld_q <= main_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
            rdy_q      <= rdy_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = main_vld_q;
    assign out_y     = main_q[WIDTH-1:0];
    assign xfer_cnt  = cnt_q;
`ifdef LOGIC_PIPE_PARITY_EN
    assign out_par   = main_q[WIDTH];
`endif

endmodule
